// File: rtl/datapath_controller.sv
// Control FSM for the simple processor datapath: fetches 16-bit instructions
// from a synchronous ROM, latches them in IR, decodes the opcode and drives
// the data memory, write-back mux, register file and ALU strobes (Moore style).
module datapath_controller #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] I_Addr,
  input  logic [15:0]     I_Data,
  output logic [3:0]      D_Addr,
  output logic            D_WriteEn,
  output logic            MuxS,
  output logic [3:0]      RegF_W_addr,
  output logic            RegF_W_en,
  output logic [3:0]      RegF_Ra_addr,
  output logic [3:0]      RegF_Rb_addr,
  output logic [2:0]      ALU_S,
  output logic [PC_W-1:0] PC_o,
  output logic [15:0]     IR_o,
  output logic [3:0]      State_o
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_FETCH2 = 4'd2,
    S_DECODE = 4'd3,
    S_NOOP   = 4'd4,
    S_STORE  = 4'd5,
    S_LOAD_A = 4'd6,
    S_LOAD_B = 4'd7,
    S_ADD    = 4'd8,
    S_SUB    = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [3:0] op, f_a, f_b, f_c;
  assign op  = ir_q[15:12];
  assign f_a = ir_q[11:8];
  assign f_b = ir_q[7:4];
  assign f_c = ir_q[3:0];

  // Next-state logic: sequencing, IR capture and PC increment (wraps naturally).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_FETCH2;
      S_FETCH2: begin
        ir_d    = I_Data;
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          4'h1:    state_d = S_STORE;
          4'h2:    state_d = S_LOAD_A;
          4'h3:    state_d = S_ADD;
          4'h4:    state_d = S_SUB;
          4'h5:    state_d = S_HALT;
          default: state_d = S_NOOP;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP, S_STORE, S_LOAD_B, S_ADD, S_SUB: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // State, PC and IR registers; reset wins over every transition including HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Control strobes decoded from state and IR; LOAD_A only covers DM read latency.
  always_comb begin
    I_Addr       = pc_q;
    D_Addr       = f_c;
    D_WriteEn    = 1'b0;
    MuxS         = 1'b0;
    RegF_W_addr  = f_c;
    RegF_W_en    = 1'b0;
    RegF_Ra_addr = f_a;
    RegF_Rb_addr = f_b;
    ALU_S        = 3'b000;
    case (state_q)
      S_INIT: begin
        I_Addr       = '0;
        D_Addr       = 4'd0;
        RegF_W_addr  = 4'd0;
        RegF_Ra_addr = 4'd0;
        RegF_Rb_addr = 4'd0;
      end
      S_STORE:  D_WriteEn = 1'b1;
      S_LOAD_A: D_Addr = f_b;
      S_LOAD_B: begin
        D_Addr    = f_b;
        RegF_W_en = 1'b1;
      end
      S_ADD: begin
        ALU_S     = 3'b001;
        MuxS      = 1'b1;
        RegF_W_en = 1'b1;
      end
      S_SUB: begin
        ALU_S     = 3'b010;
        MuxS      = 1'b1;
        RegF_W_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign PC_o    = pc_q;
  assign IR_o    = ir_q;
  assign State_o = state_q;

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller: a behavioural datapath (ROM, DM, RF, ALU)
// around the DUT, an instruction-level reference model that predicts every
// write transaction and its cycle, and a monitor that checks DUT writes.
module tb_datapath_controller;

  localparam int PC_W = 7;

  logic            clk;
  logic            reset;
  logic [PC_W-1:0] I_Addr;
  logic [15:0]     I_Data;
  logic [3:0]      D_Addr;
  logic            D_WriteEn;
  logic            MuxS;
  logic [3:0]      RegF_W_addr;
  logic            RegF_W_en;
  logic [3:0]      RegF_Ra_addr;
  logic [3:0]      RegF_Rb_addr;
  logic [2:0]      ALU_S;
  logic [PC_W-1:0] PC_o;
  logic [15:0]     IR_o;
  logic [3:0]      State_o;

  datapath_controller #(.PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .I_Addr(I_Addr), .I_Data(I_Data),
    .D_Addr(D_Addr), .D_WriteEn(D_WriteEn), .MuxS(MuxS),
    .RegF_W_addr(RegF_W_addr), .RegF_W_en(RegF_W_en),
    .RegF_Ra_addr(RegF_Ra_addr), .RegF_Rb_addr(RegF_Rb_addr),
    .ALU_S(ALU_S), .PC_o(PC_o), .IR_o(IR_o), .State_o(State_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath
  logic [15:0] rom     [128];
  logic [15:0] rf_init [16];
  logic [15:0] dm_init [16];
  logic [15:0] rf      [16];
  logic [15:0] dm      [16];
  logic [15:0] dm_rdata, ra, rb, alu_y, wb;
  int          cyc;

  always @(posedge clk) begin
    I_Data   <= rom[I_Addr];
    dm_rdata <= dm[D_Addr];
    if (reset) begin
      rf <= rf_init;
      dm <= dm_init;
    end else begin
      if (D_WriteEn) dm[D_Addr] <= rf[RegF_Ra_addr];
      if (RegF_W_en) rf[RegF_W_addr] <= wb;
    end
  end

  always_comb begin
    ra = rf[RegF_Ra_addr];
    rb = rf[RegF_Rb_addr];
    case (ALU_S)
      3'b001:  alu_y = ra + rb;
      3'b010:  alu_y = ra - rb;
      default: alu_y = ra;
    endcase
    wb = MuxS ? alu_y : dm_rdata;
  end

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Scoreboard
  typedef struct packed {
    logic [1:0]  we;     // {D_WriteEn, RegF_W_en}
    logic [3:0]  addr;   // destination address
    logic [3:0]  daddr;  // D_Addr seen during the write
    logic [15:0] data;   // value written
    logic        muxs;
    logic [2:0]  alu;
    logic [31:0] t;      // cycle index after reset release (INIT = 0)
  } ev_t;

  ev_t exp_q[$];
  ev_t act_ev, exp_ev;
  int  vectors = 0;
  int  miscompares = 0;

  logic [15:0]     m_rf [16];
  logic [15:0]     m_dm [16];
  bit              halted;
  logic [PC_W-1:0] halt_pc;
  logic [15:0]     halt_ir;
  int              halt_t, stop_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe is a transaction popped against the model.
  always @(negedge clk) begin
    if (D_WriteEn || RegF_W_en) begin
      act_ev.we    = {D_WriteEn, RegF_W_en};
      act_ev.addr  = D_WriteEn ? D_Addr : RegF_W_addr;
      act_ev.daddr = D_Addr;
      act_ev.data  = D_WriteEn ? rf[RegF_Ra_addr] : wb;
      act_ev.muxs  = MuxS;
      act_ev.alu   = ALU_S;
      act_ev.t     = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got %h expected none (cycle %0d)", act_ev, cyc);
      end else begin
        exp_ev = exp_q.pop_front();
        if (act_ev !== exp_ev) begin
          miscompares++;
          $display("FAIL write_txn: got %h expected %h (cycle %0d)", act_ev, exp_ev, cyc);
        end else begin
          $display("txn cycle=%0d we=%b addr=%0d data=%h ok", cyc, act_ev.we, act_ev.addr, act_ev.data);
        end
      end
    end
  end

  // Instruction-level reference model: FETCH at t, execute at t+3,
  // next FETCH at t+4 (t+5 for LOAD, whose write lands at t+4).
  task automatic model(input int budget);
    int              t;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    ev_t             e;
    m_rf   = rf_init;
    m_dm   = dm_init;
    pc     = '0;
    t      = 1;
    halted = 1'b0;
    exp_q.delete();
    while (!halted && t < budget) begin
      ir = rom[pc];
      pc = pc + 1'b1;
      e  = '0;
      e.daddr = ir[3:0];
      e.addr  = ir[3:0];
      case (ir[15:12])
        4'h1: begin
          e.we = 2'b10; e.data = m_rf[ir[11:8]]; e.t = t + 3;
          m_dm[ir[3:0]] = m_rf[ir[11:8]];
          exp_q.push_back(e); t += 4;
        end
        4'h2: begin
          e.we = 2'b01; e.daddr = ir[7:4]; e.data = m_dm[ir[7:4]]; e.t = t + 4;
          m_rf[ir[3:0]] = m_dm[ir[7:4]];
          exp_q.push_back(e); t += 5;
        end
        4'h3, 4'h4: begin
          e.we = 2'b01; e.muxs = 1'b1; e.t = t + 3;
          if (ir[15:12] == 4'h3) begin
            e.alu = 3'b001; e.data = m_rf[ir[11:8]] + m_rf[ir[7:4]];
          end else begin
            e.alu = 3'b010; e.data = m_rf[ir[11:8]] - m_rf[ir[7:4]];
          end
          m_rf[ir[3:0]] = e.data;
          exp_q.push_back(e); t += 4;
        end
        4'h5: begin
          halted = 1'b1; halt_pc = pc; halt_ir = ir; halt_t = t + 3;
        end
        default: t += 4;
      endcase
    end
    stop_t = halted ? halt_t + 22 : t;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      rf_init[i] = 16'h0000;
      dm_init[i] = 16'h0000;
    end
  endtask

  task automatic run_prog(input int budget);
    model(budget);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {State_o, PC_o, IR_o, I_Addr, D_Addr, D_WriteEn, MuxS,
                            RegF_W_addr, RegF_W_en, RegF_Ra_addr, RegF_Rb_addr, ALU_S}, '0);
    reset = 1'b0;
    @(negedge clk);
    check("fetch_state", {State_o, I_Addr}, {4'd1, 7'd0});
    @(negedge clk);
    check("fetch2_state", State_o, 4'd2);
    @(negedge clk);
    check("decode_state_pc", {State_o, PC_o}, {4'd3, 7'd1});
    check("ir_latch", IR_o, rom[0]);
    while (cyc < stop_t) begin
      @(negedge clk);
      if (halted && cyc >= halt_t)
        check("halt_hold", {State_o, PC_o, IR_o}, {4'd10, halt_pc, halt_ir});
    end
    check("pending_writes", exp_q.size(), 0);
    exp_q.delete();
    if (halted) begin
      for (int i = 0; i < 16; i++) begin
        check("rf_final", {i[7:0], rf[i]}, {i[7:0], m_rf[i]});
        check("dm_final", {i[7:0], dm[i]}, {i[7:0], m_dm[i]});
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    int          len, op;
    reset = 1'b1;
    clear_mem();

    // LOAD
    rom[0] = 16'h2051; rom[1] = 16'h5000; dm_init[5] = 16'h00AB;
    run_prog(1000);

    // ADD then SUB
    clear_mem();
    rf_init[1] = 16'd7; rf_init[2] = 16'd3;
    rom[0] = 16'h3123; rom[1] = 16'h4124; rom[2] = 16'h5000;
    run_prog(1000);

    // STORE then unknown opcode
    clear_mem();
    rf_init[3] = 16'h1234;
    rom[0] = 16'h1305; rom[1] = 16'hF000; rom[2] = 16'h5000;
    run_prog(1000);

    // Reset during LOAD_A: no register write may follow
    clear_mem();
    rom[0] = 16'h2051; dm_init[5] = 16'h00AB;
    exp_q.delete();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("load_a_state", {State_o, D_Addr, RegF_W_en}, {4'd6, 4'd5, 1'b0});
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_op", {State_o, PC_o, IR_o}, '0);
    repeat (3) @(negedge clk);

    // PC wrap with 128 NOOP-class instructions
    clear_mem();
    for (int i = 0; i < 128; i++) begin
      r  = $urandom();
      op = $urandom_range(0, 10);
      rom[i] = {(op == 0) ? 4'h0 : 4'(op + 5), r[11:0]};
    end
    run_prog(513);
    check("wrap_fetch", {State_o, PC_o, I_Addr}, {4'd1, 7'd0, 7'd0});
    repeat (2) @(negedge clk);
    check("wrap_decode", {State_o, PC_o, IR_o}, {4'd3, 7'd1, rom[0]});

    // Random programs ending in HALT
    for (int p = 0; p < 10; p++) begin
      clear_mem();
      for (int i = 0; i < 16; i++) begin
        r = $urandom(); rf_init[i] = r[15:0];
        r = $urandom(); dm_init[i] = r[15:0];
      end
      len = $urandom_range(5, 30);
      for (int i = 0; i < len; i++) begin
        r  = $urandom();
        op = $urandom_range(0, 14);
        if (op >= 5) op = op + 1;
        rom[i] = {4'(op), r[11:0]};
      end
      r = $urandom();
      rom[len] = {4'h5, r[11:0]};
      run_prog(1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
